arbitro_round_robin: RTL and testbench
======================================

Name: arbitro_round_robin

Overview:
- Four-lane to one-lane merger. It sits at the boundary after the 4-output demux tree and serialises the four 8-bit lanes back onto one shared 8-bit channel.
- Each lane is buffered in its own small FIFO.
- A round-robin scheduler grants the shared output register to one non-empty lane per transfer.
- The downstream consumer applies backpressure through `ready`.

Parameters:
- DATA_W, 8, lane and output data width.
- FIFO_DEPTH, 4, entries per lane FIFO; must be a power of 2.
- ADDR_W, 2, log2(FIFO_DEPTH); width of the FIFO read and write pointers.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- valid_in0..valid_in3  input  1 each  lane N write strobe.
- data_in0..data_in3  input  DATA_W each  lane N write data.
- full0..full3  output  1 each  lane N FIFO holds FIFO_DEPTH entries.
- ready  input  1  downstream accepts the output word this cycle.
- valid_out  output  1  data_out/lane_out hold a word.
- data_out  output  DATA_W  granted word.
- lane_out  output  2  index of the lane data_out came from.
- err_overflow  output  4  sticky per-lane drop flag.

Behaviour:
- Reset (asynchronous, active-high): all FIFO counts and pointers go to 0, and full0..3 go to 0. valid_out=0, data_out=0, lane_out=0, err_overflow=0. The last-grant pointer goes to 3, so lane 0 has first priority. Reset mid-transfer discards every buffered word immediately.
- Write:
  - valid_inN=1 and fullN=0 → push data_inN; countN+1.
  - valid_inN=1 and fullN=1 → word dropped, err_overflow[N] set. The flag stays set until reset.
  - fullN is computed from the registered count. A push on a full FIFO is dropped even if the same cycle pops that lane.
- Output stage (2 states):
  - EMPTY: valid_out=0.
  - HOLD: valid_out=1. data_out and lane_out stay stable while ready=0.
- Load condition: state is EMPTY, or state is HOLD with ready=1. On a load cycle:
  - Search lanes cyclically from last_grant+1 (mod 4).
  - The first non-empty lane (count>0, registered) wins. Pop it, register its head into data_out, set lane_out=N and last_grant=N, and go to HOLD.
  - If no lane is non-empty, go to EMPTY and set valid_out=0. data_out and lane_out keep their last values.
- Latency: a word pushed at edge k appears on valid_out after edge k+1, provided the output stage is loadable and no other lane wins.
- Throughput: with ready held high, the block delivers one word per cycle.
- Simultaneous push and pop on the same lane: count is unchanged and the pointers both advance.
- Wrap-around: pointers are ADDR_W bits and wrap naturally. Count is ADDR_W+1 bits, range 0..FIFO_DEPTH.
- Fairness: a lane that was just granted has lowest priority on the next load. With all four lanes backlogged the grant order is 0,1,2,3,0,…
- Total buffering per lane is FIFO_DEPTH+1 words while the output stage holds that lane's word.

Decomposition:
- Shared package/include: DATA_W, FIFO_DEPTH, ADDR_W defaults; lane-index width (2); output-stage state encodings EMPTY=0, HOLD=1.
- Sub-module: fifo_lane, a single synchronous FIFO.
  - Inputs: clk, reset, push, data_in, pop.
  - Outputs: head data, full, empty, overflow.
  - It is instantiated four times.
- Arbitration and the output stage live in the top module.

Test Plan:
- Reset: assert reset mid-stream with lanes 0 and 2 holding data → same cycle valid_out=0, full0..3=0, err_overflow=0; after release, pushes start from empty FIFOs and lane 0 has first priority.
- Single lane: ready=1; push 0xA5 on lane 2 at edge k → after edge k+1, valid_out=1, data_out=0xA5, lane_out=2; after edge k+2, valid_out=0.
- Simultaneous lanes: ready=1; one cycle with all four valid_in high carrying 0x10/0x21/0x32/0x43 → output on four consecutive cycles is 0x10(0), 0x21(1), 0x32(2), 0x43(3), then valid_out=0.
- Backpressure and overflow: ready=0; push 0x01..0x06 on lane 1 on six consecutive edges.
  - Expected: data_out=0x01 held stable; full1=1 after the 5th push; 0x06 dropped; err_overflow=4'b0010.
  - Then ready=1 → output 0x01..0x05 in order, full1 clears, err_overflow stays 4'b0010.
- Fairness: ready=1; lanes 0 and 3 pushed every cycle → lane_out alternates 0,3,0,3 with no starvation; lane 0 and lane 3 outputs each stay in push order.
- Full with pop: ready=1; lane 1 full (count=4) while push and pop coincide → push dropped and err_overflow[1] set; count becomes 3.

Source files
------------

// File: rtl/arbitro_round_robin_pkg.sv
// rtl/arbitro_round_robin_pkg.sv - shared widths, lane count and output-stage states for the lane merger
package arbitro_round_robin_pkg;

    localparam int DATA_W_DEF     = 8;
    localparam int FIFO_DEPTH_DEF = 4;
    localparam int ADDR_W_DEF     = 2;
    localparam int LANE_W         = 2;
    localparam int NUM_LANES      = 4;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_HOLD  = 1'b1
    } out_state_t;

    // Cyclic lane successor; wraps through the 2-bit lane index.
    function automatic logic [LANE_W-1:0] next_lane(input logic [LANE_W-1:0] lane, input int step);
        return lane + LANE_W'(step);
    endfunction

endpackage

// File: rtl/fifo_lane.sv
// rtl/fifo_lane.sv - single-lane synchronous FIFO with sticky overflow flag
module fifo_lane
    import arbitro_round_robin_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int ADDR_W     = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] data_in,
    input  logic              pop,
    output logic [DATA_W-1:0] head,
    output logic              full,
    output logic              empty,
    output logic              overflow
);

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   count;
    logic              do_push;
    logic              do_pop;

    // Full comes from the registered count, so a same-cycle pop never frees a slot for a push.
    assign full    = (count == (ADDR_W+1)'(FIFO_DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (push && full) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= data_in;
    end

endmodule

// File: rtl/arbitro_round_robin.sv
// rtl/arbitro_round_robin.sv - four buffered lanes merged round-robin onto one backpressured channel
module arbitro_round_robin
    import arbitro_round_robin_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int ADDR_W     = ADDR_W_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 valid_in0,
    input  logic                 valid_in1,
    input  logic                 valid_in2,
    input  logic                 valid_in3,
    input  logic [DATA_W-1:0]    data_in0,
    input  logic [DATA_W-1:0]    data_in1,
    input  logic [DATA_W-1:0]    data_in2,
    input  logic [DATA_W-1:0]    data_in3,
    output logic                 full0,
    output logic                 full1,
    output logic                 full2,
    output logic                 full3,
    input  logic                 ready,
    output logic                 valid_out,
    output logic [DATA_W-1:0]    data_out,
    output logic [LANE_W-1:0]    lane_out,
    output logic [NUM_LANES-1:0] err_overflow
);

    logic [NUM_LANES-1:0] lane_push;
    logic [NUM_LANES-1:0] lane_pop;
    logic [NUM_LANES-1:0] lane_full;
    logic [NUM_LANES-1:0] lane_empty;
    logic [NUM_LANES-1:0] lane_ovf;
    logic [DATA_W-1:0]    lane_wdata [NUM_LANES];
    logic [DATA_W-1:0]    lane_head  [NUM_LANES];

    assign lane_push     = {valid_in3, valid_in2, valid_in1, valid_in0};
    assign lane_wdata[0] = data_in0;
    assign lane_wdata[1] = data_in1;
    assign lane_wdata[2] = data_in2;
    assign lane_wdata[3] = data_in3;

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        fifo_lane #(
            .DATA_W     (DATA_W),
            .FIFO_DEPTH (FIFO_DEPTH),
            .ADDR_W     (ADDR_W)
        ) u_fifo (
            .clk      (clk),
            .reset    (reset),
            .push     (lane_push[g]),
            .data_in  (lane_wdata[g]),
            .pop      (lane_pop[g]),
            .head     (lane_head[g]),
            .full     (lane_full[g]),
            .empty    (lane_empty[g]),
            .overflow (lane_ovf[g])
        );
    end

    assign full0        = lane_full[0];
    assign full1        = lane_full[1];
    assign full2        = lane_full[2];
    assign full3        = lane_full[3];
    assign err_overflow = lane_ovf;

    out_state_t        state;
    out_state_t        state_nxt;
    logic [DATA_W-1:0] data_nxt;
    logic [LANE_W-1:0] lane_nxt;
    logic [LANE_W-1:0] last_grant;
    logic [LANE_W-1:0] last_nxt;
    logic [LANE_W-1:0] cand;
    logic              load;
    logic              found;

    assign valid_out = (state == ST_HOLD);

    // Search starts one past the last grant, so the lane just served ranks lowest.
    always_comb begin
        state_nxt = state;
        data_nxt  = data_out;
        lane_nxt  = lane_out;
        last_nxt  = last_grant;
        lane_pop  = '0;
        found     = 1'b0;
        cand      = last_grant;
        load      = (state == ST_EMPTY) || ready;
        if (load) begin
            state_nxt = ST_EMPTY;
            for (int step = 1; step <= NUM_LANES; step++) begin
                cand = next_lane(last_grant, step);
                if (!found && !lane_empty[cand]) begin
                    found          = 1'b1;
                    lane_pop[cand] = 1'b1;
                    data_nxt       = lane_head[cand];
                    lane_nxt       = cand;
                    last_nxt       = cand;
                    state_nxt      = ST_HOLD;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_EMPTY;
            data_out   <= '0;
            lane_out   <= '0;
            last_grant <= LANE_W'(NUM_LANES - 1);
        end else begin
            state      <= state_nxt;
            data_out   <= data_nxt;
            lane_out   <= lane_nxt;
            last_grant <= last_nxt;
        end
    end

endmodule

// File: tb/tb_arbitro_round_robin.sv
// tb/tb_arbitro_round_robin.sv - vector table, directed corners and queue-model random check of the lane merger
module tb_arbitro_round_robin;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] vin;
    logic [7:0] din [4];
    logic       ready;
    logic       full0, full1, full2, full3;
    logic       valid_out;
    logic [7:0] data_out;
    logic [1:0] lane_out;
    logic [3:0] err_overflow;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    arbitro_round_robin dut (
        .clk          (clk),
        .reset        (reset),
        .valid_in0    (vin[0]),
        .valid_in1    (vin[1]),
        .valid_in2    (vin[2]),
        .valid_in3    (vin[3]),
        .data_in0     (din[0]),
        .data_in1     (din[1]),
        .data_in2     (din[2]),
        .data_in3     (din[3]),
        .full0        (full0),
        .full1        (full1),
        .full2        (full2),
        .full3        (full3),
        .ready        (ready),
        .valid_out    (valid_out),
        .data_out     (data_out),
        .lane_out     (lane_out),
        .err_overflow (err_overflow)
    );

    // Reference model: one queue per lane plus the visible output word.
    logic [7:0] mq [4][$];
    logic       m_valid;
    logic [7:0] m_data;
    logic [1:0] m_lane;
    int         m_last;
    logic [3:0] m_err;

    task automatic model_reset();
        for (int l = 0; l < 4; l++) mq[l].delete();
        m_valid = 1'b0;
        m_data  = 8'h00;
        m_lane  = 2'd0;
        m_last  = 3;
        m_err   = 4'b0000;
    endtask

    task automatic model_step();
        int  sz [4];
        int  l;
        bit  found;
        for (int i = 0; i < 4; i++) sz[i] = mq[i].size();
        if (!m_valid || ready) begin
            found = 0;
            for (int k = 1; k <= 4; k++) begin
                l = (m_last + k) % 4;
                if (!found && sz[l] > 0) begin
                    found  = 1;
                    m_data = mq[l].pop_front();
                    m_lane = 2'(l);
                    m_last = l;
                end
            end
            m_valid = found;
        end
        for (int i = 0; i < 4; i++) begin
            if (vin[i]) begin
                if (sz[i] >= 4) m_err[i] = 1'b1;
                else            mq[i].push_back(din[i]);
            end
        end
    endtask

    function automatic logic [18:0] snap();
        return {valid_out, data_out, lane_out, full3, full2, full1, full0, err_overflow};
    endfunction

    task automatic cmp_out(input string name, input logic [18:0] exp);
        logic [18:0] got;
        got = snap();
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got v=%0b d=%02h lane=%0d full=%04b err=%04b, expected v=%0b d=%02h lane=%0d full=%04b err=%04b",
                     name, got[18], got[17:10], got[9:8], got[7:4], got[3:0],
                     exp[18], exp[17:10], exp[9:8], exp[7:4], exp[3:0]);
        end
    endtask

    task automatic expect_out(input string name, input logic ev, input logic [7:0] ed,
                              input logic [1:0] el, input logic [3:0] ef, input logic [3:0] ee);
        cmp_out(name, {ev, ed, el, ef, ee});
    endtask

    task automatic model_check(input string name);
        logic [3:0] ef;
        for (int l = 0; l < 4; l++) ef[l] = (mq[l].size() == 4);
        cmp_out(name, {m_valid, m_data, m_lane, ef, m_err});
    endtask

    task automatic tick();
        @(posedge clk);
        if (!reset) model_step();
        #1;
    endtask

    task automatic drive(input logic [3:0] v, input logic [7:0] d0, input logic [7:0] d1,
                         input logic [7:0] d2, input logic [7:0] d3, input logic r);
        vin = v; din[0] = d0; din[1] = d1; din[2] = d2; din[3] = d3; ready = r;
    endtask

    typedef struct {
        logic [3:0] vin;
        logic [7:0] d0, d1, d2, d3;
        logic       rdy;
        logic       ev;
        logic [7:0] ed;
        logic [1:0] el;
        logic [3:0] ef;
        logic [3:0] ee;
    } vec_t;

    vec_t tbl [$];

    function automatic vec_t mk(input logic [3:0] v, input logic [7:0] d0, input logic [7:0] d1,
                                input logic [7:0] d2, input logic [7:0] d3, input logic r,
                                input logic ev, input logic [7:0] ed, input logic [1:0] el,
                                input logic [3:0] ef, input logic [3:0] ee);
        vec_t t;
        t.vin = v; t.d0 = d0; t.d1 = d1; t.d2 = d2; t.d3 = d3; t.rdy = r;
        t.ev = ev; t.ed = ed; t.el = el; t.ef = ef; t.ee = ee;
        return t;
    endfunction

    initial begin
        int exp_l;

        // Simultaneous lanes, then single lane, then backpressure with overflow on lane 1.
        tbl.push_back(mk(4'b1111, 8'h10, 8'h21, 8'h32, 8'h43, 1, 0, 8'h00, 0, 4'b0000, 4'b0000));
        tbl.push_back(mk(4'b0000, 0, 0, 0, 0, 1, 1, 8'h10, 0, 4'b0000, 4'b0000));
        tbl.push_back(mk(4'b0000, 0, 0, 0, 0, 1, 1, 8'h21, 1, 4'b0000, 4'b0000));
        tbl.push_back(mk(4'b0000, 0, 0, 0, 0, 1, 1, 8'h32, 2, 4'b0000, 4'b0000));
        tbl.push_back(mk(4'b0000, 0, 0, 0, 0, 1, 1, 8'h43, 3, 4'b0000, 4'b0000));
        tbl.push_back(mk(4'b0000, 0, 0, 0, 0, 1, 0, 8'h43, 3, 4'b0000, 4'b0000));
        tbl.push_back(mk(4'b0100, 0, 0, 8'hA5, 0, 1, 0, 8'h43, 3, 4'b0000, 4'b0000));
        tbl.push_back(mk(4'b0000, 0, 0, 0, 0, 1, 1, 8'hA5, 2, 4'b0000, 4'b0000));
        tbl.push_back(mk(4'b0000, 0, 0, 0, 0, 1, 0, 8'hA5, 2, 4'b0000, 4'b0000));
        tbl.push_back(mk(4'b0010, 0, 8'h01, 0, 0, 0, 0, 8'hA5, 2, 4'b0000, 4'b0000));
        tbl.push_back(mk(4'b0010, 0, 8'h02, 0, 0, 0, 1, 8'h01, 1, 4'b0000, 4'b0000));
        tbl.push_back(mk(4'b0010, 0, 8'h03, 0, 0, 0, 1, 8'h01, 1, 4'b0000, 4'b0000));
        tbl.push_back(mk(4'b0010, 0, 8'h04, 0, 0, 0, 1, 8'h01, 1, 4'b0000, 4'b0000));
        tbl.push_back(mk(4'b0010, 0, 8'h05, 0, 0, 0, 1, 8'h01, 1, 4'b0010, 4'b0000));
        tbl.push_back(mk(4'b0010, 0, 8'h06, 0, 0, 0, 1, 8'h01, 1, 4'b0010, 4'b0010));
        tbl.push_back(mk(4'b0000, 0, 0, 0, 0, 1, 1, 8'h02, 1, 4'b0000, 4'b0010));
        tbl.push_back(mk(4'b0000, 0, 0, 0, 0, 1, 1, 8'h03, 1, 4'b0000, 4'b0010));
        tbl.push_back(mk(4'b0000, 0, 0, 0, 0, 1, 1, 8'h04, 1, 4'b0000, 4'b0010));
        tbl.push_back(mk(4'b0000, 0, 0, 0, 0, 1, 1, 8'h05, 1, 4'b0000, 4'b0010));
        tbl.push_back(mk(4'b0000, 0, 0, 0, 0, 1, 0, 8'h05, 1, 4'b0000, 4'b0010));

        drive(4'b0000, 0, 0, 0, 0, 1'b1);
        reset = 1'b1;
        model_reset();
        #2;
        expect_out("reset_state", 0, 8'h00, 0, 4'b0000, 4'b0000);
        @(posedge clk); #1;
        reset = 1'b0;

        foreach (tbl[i]) begin
            drive(tbl[i].vin, tbl[i].d0, tbl[i].d1, tbl[i].d2, tbl[i].d3, tbl[i].rdy);
            tick();
            expect_out($sformatf("table_row%0d", i), tbl[i].ev, tbl[i].ed, tbl[i].el, tbl[i].ef, tbl[i].ee);
        end

        // Mid-stream reset with lanes 0 and 2 holding data.
        drive(4'b0101, 8'h60, 0, 8'h62, 0, 1'b0);
        tick();
        drive(4'b0101, 8'h61, 0, 8'h63, 0, 1'b0);
        tick();
        drive(4'b0000, 0, 0, 0, 0, 1'b0);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        expect_out("reset_async", 0, 8'h00, 0, 4'b0000, 4'b0000);
        tick();
        expect_out("reset_held", 0, 8'h00, 0, 4'b0000, 4'b0000);
        reset = 1'b0;

        drive(4'b1001, 8'h50, 0, 0, 8'h53, 1'b1);
        tick();
        expect_out("post_reset_push", 0, 8'h00, 0, 4'b0000, 4'b0000);
        drive(4'b0000, 0, 0, 0, 0, 1'b1);
        tick();
        expect_out("post_reset_lane0_first", 1, 8'h50, 0, 4'b0000, 4'b0000);
        tick();
        expect_out("post_reset_lane3", 1, 8'h53, 3, 4'b0000, 4'b0000);
        tick();
        expect_out("post_reset_drained", 0, 8'h53, 3, 4'b0000, 4'b0000);

        // Full lane 1 with a coinciding pop: push dropped, one slot frees.
        drive(4'b0010, 0, 8'h11, 0, 0, 1'b0); tick();
        expect_out("fp_push1", 0, 8'h53, 3, 4'b0000, 4'b0000);
        drive(4'b0010, 0, 8'h12, 0, 0, 1'b0); tick();
        expect_out("fp_push2", 1, 8'h11, 1, 4'b0000, 4'b0000);
        drive(4'b0010, 0, 8'h13, 0, 0, 1'b0); tick();
        drive(4'b0010, 0, 8'h14, 0, 0, 1'b0); tick();
        drive(4'b0010, 0, 8'h15, 0, 0, 1'b0); tick();
        expect_out("fp_full", 1, 8'h11, 1, 4'b0010, 4'b0000);
        drive(4'b0010, 0, 8'h16, 0, 0, 1'b1); tick();
        expect_out("fp_push_pop", 1, 8'h12, 1, 4'b0000, 4'b0010);
        drive(4'b0000, 0, 0, 0, 0, 1'b1); tick();
        expect_out("fp_drain13", 1, 8'h13, 1, 4'b0000, 4'b0010);
        tick();
        expect_out("fp_drain14", 1, 8'h14, 1, 4'b0000, 4'b0010);
        tick();
        expect_out("fp_drain15", 1, 8'h15, 1, 4'b0000, 4'b0010);
        tick();
        expect_out("fp_empty", 0, 8'h15, 1, 4'b0000, 4'b0010);

        // Fairness between lanes 0 and 3 from a fresh reset.
        reset = 1'b1;
        model_reset();
        tick();
        reset = 1'b0;
        exp_l = 0;
        for (int c = 0; c < 16; c++) begin
            drive(4'b1001, 8'(c), 0, 0, 8'(8'h80 + c), 1'b1);
            tick();
            model_check($sformatf("fair_model%0d", c));
            if (valid_out) begin
                n_vec++;
                if (int'(lane_out) != exp_l) begin
                    n_bad++;
                    $display("FAIL fair_alternate%0d: lane_out=%0d expected %0d", c, lane_out, exp_l);
                end
                exp_l = (exp_l == 0) ? 3 : 0;
            end
        end

        // Random traffic against the queue model.
        for (int c = 0; c < 1500; c++) begin
            drive(4'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                  ($urandom_range(0, 3) != 0));
            tick();
            model_check($sformatf("rand%0d", c));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
